// File: rtl/garage_door_pkg.sv
// Shared definitions for the garage door motion sequencer: state encoding,
// travel direction and default timing parameters.
package garage_door_pkg;

    typedef enum logic [2:0] {
        STOPPED     = 3'd0,
        IDLE_CLOSED = 3'd1,
        OPENING     = 3'd2,
        IDLE_OPEN   = 3'd3,
        CLOSING     = 3'd4,
        DEADTIME    = 3'd5,
        FAULT       = 3'd6
    } state_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES  = 4;
    localparam int unsigned DEF_DEADTIME_CYCLES  = 8;
    localparam int unsigned DEF_TRAVEL_TIMEOUT   = 1000;
    localparam int unsigned DEF_AUTOCLOSE_CYCLES = 2000;
    localparam int unsigned DEF_CNT_W            = 16;

endpackage

// File: rtl/door_btn_debounce.sv
// Push-button debouncer: the level output rises once the raw input has been
// sampled high on DEBOUNCE_CYCLES consecutive edges, and drops as soon as a
// low sample is seen.
module door_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level
);

    localparam int unsigned W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [W-1:0] CNT_LAST = W'(DEBOUNCE_CYCLES - 1);
    localparam logic [W-1:0] CNT_FULL = W'(DEBOUNCE_CYCLES);

    logic [W-1:0] cnt;

    // Count consecutive high samples, saturating at the threshold
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (!raw) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (cnt != CNT_FULL) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                level <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/garage_door_motion_sequencer.sv
// Top-level garage door control: debounces and merges the wall button and
// remote into a single request pulse, then sequences the motor pair with
// dead-time on reversal, obstruction reversal, auto-close and fault latching.
module garage_door_motion_sequencer
    import garage_door_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned DEADTIME_CYCLES  = DEF_DEADTIME_CYCLES,
    parameter int unsigned TRAVEL_TIMEOUT   = DEF_TRAVEL_TIMEOUT,
    parameter int unsigned AUTOCLOSE_CYCLES = DEF_AUTOCLOSE_CYCLES,
    parameter int unsigned CNT_W            = DEF_CNT_W
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Btn_Wall,
    input  logic       Btn_Remote,
    input  logic       Obstruct,
    input  logic       UP_Max,
    input  logic       DN_Max,
    output logic       UP_M,
    output logic       DN_M,
    output logic       Fault,
    output logic [2:0] State
);

    // Timer is cleared on the entry edge, so comparing against N-1 makes the
    // state last exactly N cycles before the timed transition fires.
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEADTIME_CYCLES - 1);
    localparam logic [CNT_W-1:0] AUTO_LAST   = CNT_W'(AUTOCLOSE_CYCLES - 1);
    localparam bit               AUTO_EN     = (AUTOCLOSE_CYCLES != 0);

    logic deb_wall;
    logic deb_remote;
    logic deb_any;
    logic deb_any_q;
    logic req;

    state_t           state;
    dir_t             last_dir;
    logic [CNT_W-1:0] timer;

    door_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_wall (
        .CLK   (CLK),
        .RST   (RST),
        .raw   (Btn_Wall),
        .level (deb_wall)
    );

    door_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_remote (
        .CLK   (CLK),
        .RST   (RST),
        .raw   (Btn_Remote),
        .level (deb_remote)
    );

    assign deb_any = deb_wall | deb_remote;

    // One-cycle request pulse on the rising edge of either debounced button
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deb_any_q <= 1'b0;
            req       <= 1'b0;
        end else begin
            deb_any_q <= deb_any;
            req       <= deb_any & ~deb_any_q;
        end
    end

    // Door sequencing FSM with shared saturating state timer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= STOPPED;
            timer    <= '0;
            last_dir <= DIR_DOWN;
        end else begin
            if (timer != '1) begin
                timer <= timer + 1'b1;
            end
            if (state != FAULT && UP_Max && DN_Max) begin
                state <= FAULT;
                timer <= '0;
            end else begin
                case (state)
                    STOPPED: begin
                        if (UP_Max) begin
                            state <= IDLE_OPEN;
                            timer <= '0;
                        end else if (DN_Max) begin
                            state <= IDLE_CLOSED;
                            timer <= '0;
                        end else if (req) begin
                            timer <= '0;
                            if (last_dir == DIR_DOWN) begin
                                state    <= OPENING;
                                last_dir <= DIR_UP;
                            end else begin
                                state    <= CLOSING;
                                last_dir <= DIR_DOWN;
                            end
                        end
                    end
                    IDLE_CLOSED: begin
                        if (req) begin
                            state    <= OPENING;
                            last_dir <= DIR_UP;
                            timer    <= '0;
                        end
                    end
                    OPENING: begin
                        if (UP_Max) begin
                            state <= IDLE_OPEN;
                            timer <= '0;
                        end else if (timer == TRAVEL_LAST) begin
                            state <= FAULT;
                            timer <= '0;
                        end else if (req) begin
                            state    <= STOPPED;
                            last_dir <= DIR_UP;
                            timer    <= '0;
                        end
                    end
                    IDLE_OPEN: begin
                        if (Obstruct) begin
                            timer <= '0;
                        end
                        if ((req && !Obstruct) || (AUTO_EN && timer == AUTO_LAST)) begin
                            state    <= CLOSING;
                            last_dir <= DIR_DOWN;
                            timer    <= '0;
                        end
                    end
                    CLOSING: begin
                        if (DN_Max) begin
                            state <= IDLE_CLOSED;
                            timer <= '0;
                        end else if (Obstruct || req) begin
                            state <= DEADTIME;
                            timer <= '0;
                        end else if (timer == TRAVEL_LAST) begin
                            state <= FAULT;
                            timer <= '0;
                        end
                    end
                    DEADTIME: begin
                        if (timer == DEAD_LAST) begin
                            state    <= OPENING;
                            last_dir <= DIR_UP;
                            timer    <= '0;
                        end
                    end
                    FAULT: begin
                        state <= FAULT;
                    end
                    default: begin
                        state <= FAULT;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

    // Moore outputs decoded straight from the state register
    always_comb begin
        UP_M  = (state == OPENING);
        DN_M  = (state == CLOSING);
        Fault = (state == FAULT);
        State = state;
    end

endmodule
